// File: rtl/dest_flow_ctrl_pkg.sv
// Shared flow-control definitions for the destination side of the VC pop path:
// default widths, the destination-bit index and the destination enum.
package dest_flow_ctrl_pkg;

  localparam int DATA_W   = 6;
  localparam int DEPTH    = 8;
  localparam int CNT_W    = 4;
  localparam int DEST_BIT = DATA_W - 1;

  typedef enum logic {
    DEST_D0 = 1'b0,
    DEST_D1 = 1'b1
  } dest_t;

  function automatic dest_t dest_of(input logic [DATA_W-1:0] word);
    return dest_t'(word[DEST_BIT]);
  endfunction

endpackage

// File: rtl/dest_flow_ctrl_if.sv
// Bus bundle between the VC pop arbiter, dest_flow_ctrl and the D0/D1 FIFOs.
// Optional STATS_EN adds the per-destination routed-word counters.
interface dest_flow_ctrl_if;
  import dest_flow_ctrl_pkg::*;

  // All strobes are single-cycle and unconditional: pop_vcN means the VC FIFO
  // presents its word on data_vcN the next cycle; push_dN writes data_dN into
  // DN that cycle; pop_dN removes one DN entry. There is no ready: the
  // fifo_pause_dN levels are the only backpressure and the arbiter obeys them.
  logic              pop_vc0;
  logic              pop_vc1;
  logic [DATA_W-1:0] data_vc0;
  logic [DATA_W-1:0] data_vc1;
  logic              pop_d0;
  logic              pop_d1;
  logic [CNT_W-1:0]  umbral_d0;
  logic [CNT_W-1:0]  umbral_d1;
  logic              push_d0;
  logic              push_d1;
  logic [DATA_W-1:0] data_d0;
  logic [DATA_W-1:0] data_d1;
  logic              fifo_pause_d0;
  logic              fifo_pause_d1;
  logic [CNT_W-1:0]  cnt_d0;
  logic [CNT_W-1:0]  cnt_d1;
  logic              err_ovf;
  logic              err_unf;
`ifdef STATS_EN
  logic [15:0]       stat_d0;
  logic [15:0]       stat_d1;
`endif

  modport slave (
    input  pop_vc0, pop_vc1, data_vc0, data_vc1, pop_d0, pop_d1,
           umbral_d0, umbral_d1,
    output push_d0, push_d1, data_d0, data_d1, fifo_pause_d0, fifo_pause_d1,
           cnt_d0, cnt_d1, err_ovf, err_unf
`ifdef STATS_EN
    , output stat_d0, stat_d1
`endif
  );

  modport master (
    output pop_vc0, pop_vc1, data_vc0, data_vc1, pop_d0, pop_d1,
           umbral_d0, umbral_d1,
    input  push_d0, push_d1, data_d0, data_d1, fifo_pause_d0, fifo_pause_d1,
           cnt_d0, cnt_d1, err_ovf, err_unf
`ifdef STATS_EN
    , input stat_d0, stat_d1
`endif
  );

endinterface

// File: rtl/dest_flow_ctrl_occ_counter.sv
// Occupancy tracker for one destination FIFO: saturating count, empty-pop
// detection and the almost-full pause compare.
module occ_counter #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [CNT_W-1:0] umbral_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             pause_o,
  output logic             ovf_o,
  output logic             unf_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Simultaneous push and pop cancel out, so neither error can fire then.
  always_comb begin
    cnt_d = cnt_q;
    ovf_o = 1'b0;
    unf_o = 1'b0;
    case ({push_i, pop_i})
      2'b10: begin
        if (cnt_q == CNT_W'(DEPTH)) ovf_o = 1'b1;
        else                        cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        if (cnt_q == '0) unf_o = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  assign cnt_o   = cnt_q;
  assign pause_o = (cnt_q >= umbral_i);

endmodule

// File: rtl/dest_flow_ctrl.sv
// Routes words popped from VC0/VC1 into D0/D1 by their destination bit and
// generates occupancy, pause and sticky error flags. Optional macro: STATS_EN.
module dest_flow_ctrl
  import dest_flow_ctrl_pkg::*;
(
  input logic            clk,
  input logic            reset,
  dest_flow_ctrl_if.slave bus
);

  logic              vld0_q, vld1_q;
  logic              push_d0_q, push_d0_d;
  logic              push_d1_q, push_d1_d;
  logic [DATA_W-1:0] data_d0_q, data_d0_d;
  logic [DATA_W-1:0] data_d1_q, data_d1_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_unf_q, err_unf_d;
  logic [DATA_W-1:0] word;
  logic              word_vld;
  logic              ovf0, ovf1, unf0, unf1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld0_q    <= 1'b0;
      vld1_q    <= 1'b0;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_d0_q <= '0;
      data_d1_q <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      vld0_q    <= bus.pop_vc0;
      vld1_q    <= bus.pop_vc1;
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
      data_d0_q <= data_d0_d;
      data_d1_q <= data_d1_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  // VC0 wins a collision; the VC1 word is lost and reported as overflow.
  always_comb begin
    word      = vld0_q ? bus.data_vc0 : bus.data_vc1;
    word_vld  = vld0_q | vld1_q;
    push_d0_d = word_vld && (dest_of(word) == DEST_D0);
    push_d1_d = word_vld && (dest_of(word) == DEST_D1);
    data_d0_d = push_d0_d ? word : data_d0_q;
    data_d1_d = push_d1_d ? word : data_d1_q;
    err_ovf_d = err_ovf_q | (vld0_q & vld1_q) | ovf0 | ovf1;
    err_unf_d = err_unf_q | unf0 | unf1;
  end

  occ_counter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_occ_d0 (
    .clk      (clk),
    .rst      (reset),
    .push_i   (push_d0_q),
    .pop_i    (bus.pop_d0),
    .umbral_i (bus.umbral_d0),
    .cnt_o    (bus.cnt_d0),
    .pause_o  (bus.fifo_pause_d0),
    .ovf_o    (ovf0),
    .unf_o    (unf0)
  );

  occ_counter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_occ_d1 (
    .clk      (clk),
    .rst      (reset),
    .push_i   (push_d1_q),
    .pop_i    (bus.pop_d1),
    .umbral_i (bus.umbral_d1),
    .cnt_o    (bus.cnt_d1),
    .pause_o  (bus.fifo_pause_d1),
    .ovf_o    (ovf1),
    .unf_o    (unf1)
  );

  assign bus.push_d0 = push_d0_q;
  assign bus.push_d1 = push_d1_q;
  assign bus.data_d0 = data_d0_q;
  assign bus.data_d1 = data_d1_q;
  assign bus.err_ovf = err_ovf_q;
  assign bus.err_unf = err_unf_q;

`ifdef STATS_EN
  logic [15:0] stat_d0_q, stat_d0_d;
  logic [15:0] stat_d1_q, stat_d1_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_d0_q <= '0;
      stat_d1_q <= '0;
    end else begin
      stat_d0_q <= stat_d0_d;
      stat_d1_q <= stat_d1_d;
    end
  end

  always_comb begin
    stat_d0_d = stat_d0_q + {15'd0, push_d0_d};
    stat_d1_d = stat_d1_q + {15'd0, push_d1_d};
  end

  assign bus.stat_d0 = stat_d0_q;
  assign bus.stat_d1 = stat_d1_q;
`endif

endmodule

// File: tb/tb_dest_flow_ctrl.sv
// Self-checking bench for dest_flow_ctrl: directed scenarios plus random
// traffic, all outputs compared every cycle against a behavioural model.
module tb_dest_flow_ctrl;
  import dest_flow_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dest_flow_ctrl_if bus();

  dest_flow_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural model: pops issued last cycle deliver their word this cycle,
  // and that word appears on its destination one cycle later.
  int                m_cnt  [2];
  bit                m_push [2];
  logic [DATA_W-1:0] m_data [2];
  bit                m_pend [2];
  int                m_stat [2];
  bit                m_ovf, m_unf;
  bit                m_pd   [2];
  logic [DATA_W-1:0] m_word;
  int                m_dst;

  always @(posedge clk) begin
    if (reset) begin
      for (int n = 0; n < 2; n++) begin
        m_cnt[n] = 0; m_push[n] = 0; m_data[n] = '0; m_pend[n] = 0; m_stat[n] = 0;
      end
      m_ovf = 0; m_unf = 0;
    end else begin
      m_pd[0] = bus.pop_d0;
      m_pd[1] = bus.pop_d1;
      for (int n = 0; n < 2; n++) begin
        if (m_push[n] && !m_pd[n]) begin
          if (m_cnt[n] == DEPTH) m_ovf = 1;
          else m_cnt[n] = m_cnt[n] + 1;
        end else if (m_pd[n] && !m_push[n]) begin
          if (m_cnt[n] == 0) m_unf = 1;
          else m_cnt[n] = m_cnt[n] - 1;
        end
      end
      if (m_pend[0] && m_pend[1]) m_ovf = 1;
      m_word  = m_pend[0] ? bus.data_vc0 : bus.data_vc1;
      m_push[0] = 0;
      m_push[1] = 0;
      if (m_pend[0] || m_pend[1]) begin
        m_dst = int'(m_word[DATA_W-1]);
        m_push[m_dst] = 1;
        m_data[m_dst] = m_word;
        m_stat[m_dst] = (m_stat[m_dst] + 1) % 65536;
      end
      m_pend[0] = bus.pop_vc0;
      m_pend[1] = bus.pop_vc1;
    end
  end

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("push_d0", 16'(bus.push_d0), 16'(m_push[0]));
    check_val("push_d1", 16'(bus.push_d1), 16'(m_push[1]));
    check_val("data_d0", 16'(bus.data_d0), 16'(m_data[0]));
    check_val("data_d1", 16'(bus.data_d1), 16'(m_data[1]));
    check_val("cnt_d0", 16'(bus.cnt_d0), 16'(m_cnt[0]));
    check_val("cnt_d1", 16'(bus.cnt_d1), 16'(m_cnt[1]));
    check_val("pause_d0", 16'(bus.fifo_pause_d0), 16'(m_cnt[0] >= int'(bus.umbral_d0)));
    check_val("pause_d1", 16'(bus.fifo_pause_d1), 16'(m_cnt[1] >= int'(bus.umbral_d1)));
    check_val("err_ovf", 16'(bus.err_ovf), 16'(m_ovf));
    check_val("err_unf", 16'(bus.err_unf), 16'(m_unf));
`ifdef STATS_EN
    check_val("stat_d0", bus.stat_d0, 16'(m_stat[0]));
    check_val("stat_d1", bus.stat_d1, 16'(m_stat[1]));
`endif
  endtask

  // Inputs change only just after the falling edge; outputs are checked there.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    bus.pop_vc0 = 0; bus.pop_vc1 = 0; bus.pop_d0 = 0; bus.pop_d1 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    bus.data_vc0 = '0; bus.data_vc1 = '0;
    bus.umbral_d0 = 4'd5; bus.umbral_d1 = 4'd5;
    @(negedge clk);

    // Reset state
    do_reset();
    check_val("rst_cnt_d0", 16'(bus.cnt_d0), 16'd0);
    check_val("rst_pause_d0", 16'(bus.fifo_pause_d0), 16'd0);
    check_val("rst_push_d1", 16'(bus.push_d1), 16'd0);

    // Single word to D0, two-cycle latency
    bus.pop_vc0 = 1; step();
    bus.pop_vc0 = 0; bus.data_vc0 = 6'b0_00101; step();
    check_val("lat_push_d0", 16'(bus.push_d0), 16'd1);
    check_val("lat_data_d0", 16'(bus.data_d0), 16'd5);
    check_val("lat_push_d1", 16'(bus.push_d1), 16'd0);
    step();
    check_val("lat_cnt_d0", 16'(bus.cnt_d0), 16'd1);

    // Six back-to-back words to D1 with threshold 4
    do_reset();
    bus.umbral_d1 = 4'd4; bus.data_vc1 = 6'b1_00011;
    for (int i = 0; i < 6; i++) begin bus.pop_vc1 = 1; step(); end
    bus.pop_vc1 = 0;
    for (int i = 0; i < 4; i++) step();
    check_val("b2b_cnt_d1", 16'(bus.cnt_d1), 16'd6);
    check_val("b2b_pause_d1", 16'(bus.fifo_pause_d1), 16'd1);
    check_val("b2b_ovf", 16'(bus.err_ovf), 16'd0);

    // Simultaneous push/pop at count 3, then empty pop
    do_reset();
    bus.data_vc0 = 6'b0_00001;
    for (int i = 0; i < 3; i++) begin bus.pop_vc0 = 1; step(); end
    bus.pop_vc0 = 0;
    for (int i = 0; i < 3; i++) step();
    bus.pop_vc0 = 1; step();
    bus.pop_vc0 = 0; step();
    check_val("pp_push_d0", 16'(bus.push_d0), 16'd1);
    bus.pop_d0 = 1; step();
    check_val("pp_cnt_d0", 16'(bus.cnt_d0), 16'd3);
    for (int i = 0; i < 3; i++) step();
    check_val("pp_empty", 16'(bus.cnt_d0), 16'd0);
    step();
    bus.pop_d0 = 0;
    check_val("unf_cnt", 16'(bus.cnt_d0), 16'd0);
    check_val("unf_set", 16'(bus.err_unf), 16'd1);
    step(); step();
    check_val("unf_sticky", 16'(bus.err_unf), 16'd1);

    // Collision: VC0 wins, overflow flagged
    do_reset();
    bus.pop_vc0 = 1; bus.pop_vc1 = 1; step();
    bus.pop_vc0 = 0; bus.pop_vc1 = 0;
    bus.data_vc0 = 6'b0_00011; bus.data_vc1 = 6'b1_00001; step();
    check_val("col_push_d0", 16'(bus.push_d0), 16'd1);
    check_val("col_data_d0", 16'(bus.data_d0), 16'd3);
    check_val("col_push_d1", 16'(bus.push_d1), 16'd0);
    check_val("col_ovf", 16'(bus.err_ovf), 16'd1);

    // Reset one cycle after a pop discards the word
    do_reset();
    bus.pop_vc0 = 1; step();
    bus.pop_vc0 = 0; reset = 1'b1; step();
    reset = 1'b0;
    step();
    check_val("rstfl_push_d0", 16'(bus.push_d0), 16'd0);
    step();
    check_val("rstfl_cnt_d0", 16'(bus.cnt_d0), 16'd0);

`ifdef STATS_EN
    do_reset();
    bus.data_vc0 = 6'b0_00111; bus.data_vc1 = 6'b1_00010;
    for (int i = 0; i < 3; i++) begin bus.pop_vc0 = 1; step(); end
    bus.pop_vc0 = 0;
    for (int i = 0; i < 2; i++) begin bus.pop_vc1 = 1; step(); end
    bus.pop_vc1 = 0;
    for (int i = 0; i < 3; i++) step();
    check_val("stats_d0", bus.stat_d0, 16'd3);
    check_val("stats_d1", bus.stat_d1, 16'd2);
`endif

    // Random traffic, including saturation, empty pops and a mid-run reset
    do_reset();
    for (int c = 0; c < 1200; c++) begin
      if (c % 60 == 0) begin
        bus.umbral_d0 = 4'($urandom_range(0, DEPTH - 3));
        bus.umbral_d1 = 4'($urandom_range(0, DEPTH - 3));
      end
      bus.pop_vc0  = ($urandom_range(0, 2) == 0);
      bus.pop_vc1  = ($urandom_range(0, 2) == 0);
      bus.data_vc0 = 6'($urandom);
      bus.data_vc1 = 6'($urandom);
      bus.pop_d0   = ($urandom_range(0, (c < 600) ? 4 : 1) == 0);
      bus.pop_d1   = ($urandom_range(0, (c < 600) ? 4 : 1) == 0);
      reset        = (c == 700);
      step();
    end
    reset = 1'b0;
    idle_inputs();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dest_flow_ctrl.md
Name: dest_flow_ctrl

Overview:
Destination-side counterpart of the VC-to-destination pop arbiter. It takes the words popped from the VC0/VC1 FIFOs and routes each one into destination FIFO D0 or D1 using the word's destination bit. It tracks D0/D1 occupancy and generates the fifo_pause_d0/fifo_pause_d1 backpressure signals that the pop arbiter consumes. It also flags overflow and underflow errors.

Parameters:
- DATA_W, 6: word width; bit DATA_W-1 is the destination bit (0 = D0, 1 = D1).
- DEPTH, 8: entries per destination FIFO.
- CNT_W, 4: occupancy counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pop_vc0  in  1  VC0 pop issued this cycle; read data arrives the next cycle.
- pop_vc1  in  1  VC1 pop issued this cycle; read data arrives the next cycle.
- data_vc0  in  DATA_W  VC0 FIFO read data, valid the cycle after pop_vc0.
- data_vc1  in  DATA_W  VC1 FIFO read data, valid the cycle after pop_vc1.
- pop_d0  in  1  downstream consumer pops D0.
- pop_d1  in  1  downstream consumer pops D1.
- umbral_d0  in  CNT_W  almost-full threshold for D0.
- umbral_d1  in  CNT_W  almost-full threshold for D1.
- push_d0  out  1  registered push strobe into D0.
- push_d1  out  1  registered push strobe into D1.
- data_d0  out  DATA_W  registered write data for D0.
- data_d1  out  DATA_W  registered write data for D1.
- fifo_pause_d0  out  1  D0 at or above threshold.
- fifo_pause_d1  out  1  D1 at or above threshold.
- cnt_d0  out  CNT_W  D0 occupancy.
- cnt_d1  out  CNT_W  D1 occupancy.
- err_ovf  out  1  sticky overflow flag.
- err_unf  out  1  sticky underflow flag.

Behaviour:
- Reset (asynchronous, active-high): every output and internal register goes to 0, including push_dN, data_dN, cnt_dN, err_* and the valid pipeline.
- Stage 1, cycle t: register vld0_q <= pop_vc0 and vld1_q <= pop_vc1.
- Stage 2, cycle t+1:
  - Select the word: vld0_q selects data_vc0, else vld1_q selects data_vc1.
  - If vld0_q and vld1_q are both high, route VC0 (priority) and set err_ovf; the VC1 word is dropped.
  - Route: if dest bit = 0, push_d0 <= 1 and data_d0 <= word; else push_d1 <= 1 and data_d1 <= word. Pushes are visible at t+2.
  - With no valid word, push_dN <= 0 and data_dN holds its last value.
- End-to-end latency from pop_vcN to push_dN is 2 cycles.
- Occupancy counter, per destination N, updated one cycle after push_dN/pop_dN:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
  - push with cnt = DEPTH: count saturates and err_ovf is set.
  - pop with cnt = 0: ignored and err_unf is set.
- Pause: fifo_pause_dN = (cnt_dN >= umbral_dN), decoded combinationally from the registered count.
  - Up to 3 words can be in flight after pause rises, so umbral_dN must be <= DEPTH-3.
  - umbral = 0 forces pause permanently high.
- err_ovf and err_unf are sticky until reset.
- Reset mid-flight discards any in-flight word; no push is produced after reset deasserts.

Optional Feature:
- Macro STATS_EN.
- When defined: add outputs stat_d0 and stat_d1, 16 bits each. Each counts words routed to its destination, wraps at 0xFFFF and resets to 0.
- When undefined: these ports and their counters do not exist; all other behaviour is unchanged.

Decomposition:
- Shared package (the one containing the existing flow-control definitions):
  - DATA_W, DEPTH and CNT_W defaults.
  - DEST_BIT index constant.
  - enum dest_t {DEST_D0, DEST_D1}.
- One sub-module, occ_counter. It holds one destination's count plus the saturation, underflow and pause compare logic. It is instantiated twice.

Test Plan:
1. Reset with all inputs 0: outputs all 0, cnt_dN = 0; with umbral = 5, fifo_pause_dN = 0.
2. pop_vc0 at t with data_vc0 = 6'b0_00101 at t+1: push_d0 = 1 and data_d0 = 5 at t+2; cnt_d0 = 1 at t+3; push_d1 stays 0.
3. DEPTH = 8, umbral_d1 = 4: six back-to-back pop_vc1 with dest bit = 1, no pop_d1. fifo_pause_d1 rises the cycle cnt_d1 reaches 4; final cnt_d1 = 6; err_ovf = 0.
4. cnt_d0 = 3 with push_d0 and pop_d0 in the same cycle: cnt_d0 stays 3. Next, pop_d0 with cnt_d0 = 0: cnt_d0 stays 0 and err_unf = 1 and stays high.
5. pop_vc0 and pop_vc1 in the same cycle: only data_vc0 is routed and err_ovf = 1. Separately, assert reset one cycle after a pop: no push emerges.
6. With STATS_EN defined: route 3 words to D0 and 2 to D1; stat_d0 = 3, stat_d1 = 2.
